// File: rtl/ahb_arb_pkg.sv
// AHB random/round-robin arbiter: shared encodings.
// Provides htrans codes, the arbiter FSM state type and the master count.
package ahb_arb_pkg;

    localparam int NUM_M = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // One-hot (4) to index; input is always one-hot here.
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/arb_lfsr6.sv
// 6-bit maximal-length LFSR (period 63) used as the random scan start.
// Ports: hclk, reset (async, active-high), q = current state.
module arb_lfsr6 #(
    parameter logic [5:0] SEED = 6'h01
) (
    input  logic       hclk,
    input  logic       reset,
    output logic [5:0] q
);

    // The all-zero state would lock up the register.
    localparam logic [5:0] INIT = (SEED == 6'h00) ? 6'h01 : SEED;

    logic [5:0] r_q;

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            r_q <= INIT;
        end else begin
            r_q <= {r_q[4:0], r_q[5] ^ r_q[0]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ahb_rand_arbiter.sv
// AHB bus arbiter for 4 masters with random-start or round-robin priority.
// In: hclk, reset, hbusreq, hlock, hready, htrans, mode_rand.
// Out: hgrant (one-hot), hmaster, hmastlock, rand_q (LFSR state).
module ahb_rand_arbiter
    import ahb_arb_pkg::*;
#(
    parameter logic [5:0] SEED      = 6'h01,
    parameter int         MAX_BEATS = 8
) (
    input  logic       hclk,
    input  logic       reset,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic       mode_rand,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic       hmastlock,
    output logic [5:0] rand_q
);

    localparam logic [5:0] BEAT_MAX = 6'(MAX_BEATS - 1);

    logic [3:0] r_gnt;
    logic [1:0] r_mst;
    logic       r_mlk;
    logic [5:0] r_beat;
    arb_state_e r_state;

    logic [5:0] w_rand;
    logic [1:0] w_own;
    logic       w_own_req;
    logic       w_others;
    logic       w_full;
    logic       w_hold;
    logic       w_limit;
    logic       w_ap;
    logic       w_xfer;
    logic [1:0] w_start;
    logic [3:0] w_cand;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic       w_found;
    logic [1:0] w_win;
    logic [3:0] w_next_gnt;
    arb_state_e w_nst;

    arb_lfsr6 #(
        .SEED (SEED)
    ) u_lfsr (
        .hclk  (hclk),
        .reset (reset),
        .q     (w_rand)
    );

    assign w_own     = oh2idx(r_gnt);
    assign w_own_req = hbusreq[w_own];
    assign w_others  = |(hbusreq & ~r_gnt);
    assign w_full    = (r_beat == BEAT_MAX);
    assign w_hold    = (r_state == ST_LOCKED) && hlock[w_own];

    // Owner still wants the bus but has used its beat quota.
    assign w_limit = (r_state != ST_IDLE) && w_own_req
                   && w_full && w_others;

    assign w_ap = hready && !w_hold
               && ((r_state == ST_IDLE) || !w_own_req || w_limit);

    assign w_xfer = (htrans == HTRANS_NONSEQ)
                 || (htrans == HTRANS_SEQ);

    assign w_start = mode_rand ? w_rand[1:0] : w_own + 2'd1;

    // A quota-forced owner sits out the scan it caused.
    assign w_cand  = hbusreq & ~(w_limit ? r_gnt : 4'b0000);
    assign w_found = |w_cand;

    // Rotate so that bit 0 is the scan start; first set bit wins.
    assign w_rot = 4'({w_cand, w_cand} >> w_start);

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end
    end

    assign w_win = w_start + w_off;

    always_comb begin
        w_next_gnt = r_gnt;
        if (w_ap) begin
            w_next_gnt = w_found ? (4'b0001 << w_win) : 4'b0001;
        end
    end

    always_comb begin
        w_nst = r_state;
        unique case (1'b1)
            !hready: w_nst = r_state;
            w_ap:    w_nst = w_found ? ST_BUSY : ST_IDLE;
            default: w_nst = hlock[w_own] ? ST_LOCKED : ST_BUSY;
        endcase
    end

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            r_gnt   <= 4'b0001;
            r_mst   <= 2'd0;
            r_mlk   <= 1'b0;
            r_beat  <= 6'd0;
            r_state <= ST_IDLE;
        end else if (hready) begin
            r_gnt   <= w_next_gnt;
            r_mst   <= w_own;
            r_mlk   <= hlock[w_own];
            r_state <= w_nst;
            if (w_next_gnt != r_gnt) begin
                r_beat <= 6'd0;
            end else if (w_xfer && !w_full) begin
                r_beat <= r_beat + 6'd1;
            end
        end
    end

    assign hgrant    = r_gnt;
    assign hmaster   = r_mst;
    assign hmastlock = r_mlk;
    assign rand_q    = w_rand;

endmodule

// File: tb/tb_ahb_rand_arbiter.sv
// Testbench for ahb_rand_arbiter: directed scenarios plus a
// behavioural reference model compared on every falling edge.
module tb_ahb_rand_arbiter;

    logic       hclk = 1'b0;
    logic       reset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;
    logic [1:0] htrans;
    logic       mode_rand;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;
    logic [5:0] rand_q;

    int checks = 0;
    int errors = 0;

    localparam int MB = 8;

    ahb_rand_arbiter #(
        .SEED      (6'h01),
        .MAX_BEATS (MB)
    ) dut (
        .hclk      (hclk),
        .reset     (reset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .hready    (hready),
        .htrans    (htrans),
        .mode_rand (mode_rand),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock),
        .rand_q    (rand_q)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: owner index, mode (0 idle, 1 owned, 2 locked),
    // beats used by the owner, and the delayed master/lock outputs.
    int         m_gnt  = 0;
    int         m_st   = 0;
    int         m_beat = 0;
    int         m_mst  = 0;
    int         m_mlk  = 0;
    logic [5:0] m_rand = 6'h01;

    always @(posedge hclk or posedge reset) begin : model
        int own;
        int start;
        int nxt;
        bit others;
        bit quota;
        bit ap;
        bit found;
        logic [5:0] r;
        if (reset) begin
            m_gnt  = 0;
            m_st   = 0;
            m_beat = 0;
            m_mst  = 0;
            m_mlk  = 0;
            m_rand = 6'h01;
        end else begin
            r = m_rand;
            m_rand = {r[4:0], r[5] ^ r[0]};
            if (hready) begin
                own    = m_gnt;
                others = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (i != own && hbusreq[i]) others = 1'b1;
                quota = (m_st != 0) && hbusreq[own]
                        && (m_beat == MB - 1) && others;
                ap = !(m_st == 2 && hlock[own])
                     && (m_st == 0 || !hbusreq[own] || quota);
                m_mst = own;
                m_mlk = hlock[own] ? 1 : 0;
                nxt = own;
                if (ap) begin
                    start = mode_rand ? int'(r % 4) : (own + 1) % 4;
                    found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && hbusreq[(start + k) % 4]
                            && !(quota && (start + k) % 4 == own)) begin
                            nxt   = (start + k) % 4;
                            found = 1'b1;
                        end
                    end
                    if (!found) nxt = 0;
                    m_st = found ? 1 : 0;
                end else begin
                    m_st = hlock[own] ? 2 : 1;
                end
                if (nxt != own) m_beat = 0;
                else if (htrans[1] && m_beat < MB - 1) m_beat++;
                m_gnt = nxt;
            end
        end
    end

    always @(negedge hclk) begin
        logic [3:0] eg;
        eg = 4'b0001 << m_gnt;
        chk("mdl_hgrant", 8'(hgrant), 8'(eg));
        chk("mdl_hmaster", 8'(hmaster), 8'(m_mst));
        chk("mdl_hmastlock", 8'(hmastlock), 8'(m_mlk));
        chk("mdl_rand_q", 8'(rand_q), 8'(m_rand));
    end

    task automatic step(input logic [3:0] rq, input logic [3:0] lk,
                        input logic rdy, input logic [1:0] tr,
                        input logic md);
        hbusreq   = rq;
        hlock     = lk;
        hready    = rdy;
        htrans    = tr;
        mode_rand = md;
        @(posedge hclk);
        #1;
    endtask

    logic [5:0] seq [8];
    logic [3:0] rr  [4];
    logic [3:0] frz [5];

    initial begin
        seq = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3E, 6'h3D};
        rr  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        frz = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b1111};
        hbusreq   = 4'b0;
        hlock     = 4'b0;
        hready    = 1'b1;
        htrans    = 2'b00;
        mode_rand = 1'b0;
        reset     = 1'b0;
        #1 reset = 1'b1;
        @(posedge hclk);
        #1;
        chk("rst_hgrant", 8'(hgrant), 8'h01);
        chk("rst_hmaster", 8'(hmaster), 8'h00);
        chk("rst_hmastlock", 8'(hmastlock), 8'h00);
        chk("rst_rand_q", 8'(rand_q), 8'h01);
        step(4'b0, 4'b0, 1'b1, 2'b00, 1'b0);
        reset = 1'b0;

        for (int i = 1; i < 8; i++) begin
            step(4'b0, 4'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("lfsr_seq%0d", i), 8'(rand_q), 8'(seq[i]));
        end
        chk("idle_default", 8'(hgrant), 8'h01);

        for (int i = 0; i < 4; i++) begin
            step(4'hF & ~(4'b0001 << m_gnt), 4'b0, 1'b1, 2'b10, 1'b0);
            chk($sformatf("rr_gnt%0d", i), 8'(hgrant), 8'(rr[i]));
            chk($sformatf("rr_mst%0d", i), 8'(hmaster), 8'(i));
        end

        step(4'b0100, 4'b0, 1'b1, 2'b11, 1'b0);
        chk("m2_gnt", 8'(hgrant), 8'h04);
        repeat (19) step(4'b0100, 4'b0, 1'b1, 2'b11, 1'b0);
        chk("m2_hold", 8'(hgrant), 8'h04);
        step(4'b0110, 4'b0, 1'b1, 2'b11, 1'b0);
        chk("quota_move", 8'(hgrant), 8'h02);
        step(4'b0100, 4'b0, 1'b1, 2'b11, 1'b0);
        chk("m2_regain", 8'(hgrant), 8'h04);

        step(4'b1000, 4'b1000, 1'b1, 2'b10, 1'b0);
        chk("m3_gnt", 8'(hgrant), 8'h08);
        repeat (12) step(4'b1111, 4'b1000, 1'b1, 2'b11, 1'b0);
        chk("lock_hold", 8'(hgrant), 8'h08);
        chk("lock_mlk", 8'(hmastlock), 8'h01);
        step(4'b1111, 4'b0000, 1'b1, 2'b11, 1'b0);
        chk("lock_release", 8'(hgrant), 8'h01);
        chk("unlock_mlk", 8'(hmastlock), 8'h00);

        step(4'b1000, 4'b1000, 1'b1, 2'b11, 1'b0);
        step(4'b1000, 4'b1000, 1'b1, 2'b11, 1'b0);
        chk("prerst_mlk", 8'(hmastlock), 8'h01);
        #3 reset = 1'b1;
        #1;
        chk("arst_hgrant", 8'(hgrant), 8'h01);
        chk("arst_hmaster", 8'(hmaster), 8'h00);
        chk("arst_hmastlock", 8'(hmastlock), 8'h00);
        chk("arst_rand_q", 8'(rand_q), 8'h01);
        step(4'b1000, 4'b1000, 1'b1, 2'b11, 1'b0);
        reset = 1'b0;

        repeat (5) step(4'b0101, 4'b0, 1'b0, 2'b00, 1'b1);
        step(4'b0101, 4'b0, 1'b1, 2'b00, 1'b1);
        chk("rand3F_win", 8'(hgrant), 8'h01);
        chk("rand3F_q", 8'(rand_q), 8'h3E);

        reset = 1'b1;
        step(4'b0, 4'b0, 1'b1, 2'b00, 1'b0);
        reset = 1'b0;
        repeat (6) step(4'b0101, 4'b0, 1'b0, 2'b00, 1'b1);
        step(4'b0101, 4'b0, 1'b1, 2'b00, 1'b1);
        chk("rand3E_win", 8'(hgrant), 8'h04);
        chk("rand3E_q", 8'(rand_q), 8'h3D);

        for (int i = 0; i < 5; i++) begin
            step(frz[i], 4'b0, 1'b0, 2'b11, 1'b1);
            chk($sformatf("frz_gnt%0d", i), 8'(hgrant), 8'h04);
            chk($sformatf("frz_mst%0d", i), 8'(hmaster), 8'h00);
        end
        chk("frz_rand", 8'(rand_q), 8'h2B);

        repeat (300) begin
            step(4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                 $urandom_range(0, 3) != 0, 2'($urandom),
                 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_rand_arbiter.md
AHB_RAND_ARBITER -- requirements
Module: ahb_rand_arbiter

Interface
REQ-001 Parameter SEED, 6'h01, initial LFSR state; the value 0 SHALL be replaced by 6'h01.
REQ-002 Parameter MAX_BEATS, 8, maximum data beats an unlocked owner keeps the bus while others request (range 2..63).
REQ-003 hclk  input  1  bus clock, all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 hbusreq  input  4  bus request, one bit per master 0..3.
REQ-006 hlock  input  4  locked-transfer request per master.
REQ-007 hready  input  1  transfer-complete from the selected slave.
REQ-008 htrans  input  2  transfer type driven by the current owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-009 mode_rand  input  1  1 = random-start priority, 0 = round-robin.
REQ-010 hgrant  output  4  one-hot grant.
REQ-011 hmaster  output  2  index of the address-phase owner.
REQ-012 hmastlock  output  1  current address-phase transfer is locked.
REQ-013 rand_q  output  6  current LFSR state, for debug and checking.

Function
REQ-014 hgrant SHALL always be one-hot; master 0 is the default master and is granted when nobody requests.
REQ-015 LFSR SHALL advance on every clock edge after reset: next = {rand_q[4:0], rand_q[5]^rand_q[0]} (period 63, never zero).
REQ-016 FSM states: IDLE (default grant, no requests), BUSY (requester owns the bus), LOCKED (owner holds hlock).
REQ-017 Arbitration point (AP) = hready=1 AND state!=LOCKED AND (state=IDLE OR hbusreq[owner]=0 OR (beat_cnt=MAX_BEATS-1 AND another master requests)).
REQ-018 At AP, the winner is the first requester found scanning upward modulo 4 from a start index: rand_q[1:0] if mode_rand=1, otherwise owner+1.
REQ-019 The winner SHALL be registered into hgrant on the same edge as the AP; no request -> hgrant=4'b0001, state IDLE; otherwise state BUSY.
REQ-020 hmaster SHALL take the index of hgrant on each edge with hready=1, giving at least one cycle of latency after a grant change.
REQ-021 hmastlock SHALL take hlock[granted index] on each edge with hready=1.
REQ-022 beat_cnt SHALL increment on edges with hready=1 and htrans in {NONSEQ, SEQ}, SHALL saturate at MAX_BEATS-1, and SHALL clear when hgrant changes.
REQ-023 BUSY->LOCKED when hready=1 and hlock[owner]=1; LOCKED->BUSY/AP when hready=1 and hlock[owner]=0; the beat limit SHALL be ignored in LOCKED.
REQ-024 hready=0 SHALL freeze hgrant, hmaster, hmastlock, beat_cnt and state; the LFSR keeps running.
REQ-025 If the owner wins again at AP, hgrant SHALL be unchanged and beat_cnt SHALL be preserved, unless the AP was forced by the beat limit, in which case the owner is excluded from that scan.

Reset
REQ-026 Reset SHALL force hgrant=4'b0001, hmaster=0, hmastlock=0, rand_q=SEED, beat_cnt=0, state IDLE, immediately and independently of hclk.
REQ-027 Reset asserted mid-transfer or in LOCKED SHALL abandon the lock; reset SHALL win over any simultaneous AP.

Structure
REQ-028 Package ahb_arb_pkg SHALL hold the htrans encodings, the FSM state enum and NUM_M=4.
REQ-029 The LFSR SHALL be a sub-module arb_lfsr6 (SEED parameter, hclk, reset, 6-bit q).

Verification
REQ-030 Reset mid-operation -> hgrant=0001, hmaster=0, hmastlock=0, rand_q=01 during reset; after release rand_q sequence is 01,03,07,0F,1F,3F,3E,3D.
REQ-031 mode_rand=0, hbusreq=1111, owner 0 releases each AP, hready=1 -> grants 0010,0100,1000,0001 in turn; hmaster follows one cycle later.
REQ-032 Master 2 alone, 20 SEQ beats, MAX_BEATS=8, then master 1 requests -> grant moves to 0010 on the edge with beat_cnt=7; master 2 regains the bus on the next AP.
REQ-033 Master 3 with hlock=1 for 12 beats, all others requesting -> hgrant stays 1000, hmastlock=1; grant is released only on the first hready edge after hlock[3]=0.
REQ-034 mode_rand=1, hbusreq=0101, AP sampled with rand_q=3F -> winner master 0 (scan 3,0); with rand_q=3E -> master 2.
REQ-035 hready held 0 for 5 cycles while hbusreq changes -> hgrant/hmaster constant and rand_q advances 5 steps.
